// File: rtl/mem_access_unit.sv
// Purpose: M-stage load/store unit; turns one pipeline memory op into a single registered data-bus transaction.
// Latency: 3 cycles minimum (IDLE issue, REQ with ack, DONE), 2 of them stalled; bus timeout after 16 REQ cycles.
// Backpressure: stallOUT freezes F/D/E/M while an op issues or waits for busAckIN; DONE releases the pipeline.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        memEnIN,
    input  logic [2:0]  memOpIN,
    input  logic [31:0] addrIN,
    input  logic [31:0] storeDataIN,
    input  logic        busAckIN,
    input  logic [31:0] busRdataIN,
    output logic        busReqOUT,
    output logic        busWeOUT,
    output logic [31:0] busAddrOUT,
    output logic [3:0]  busByteEnOUT,
    output logic [31:0] busWdataOUT,
    output logic [31:0] RDOUT,
    output logic        stallOUT,
    output logic        excAdELOUT,
    output logic        excAdESOUT,
    output logic        busErrOUT
);

    // Memory op encodings as presented by the decoder
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    // Wait budget: the 16th REQ cycle without ack ends the access
    localparam logic [3:0] WAIT_LAST = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Registered bus-side state
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_bus_err;
    logic [3:0]  r_wait_cnt;

    // Op context latched at issue; the pipeline inputs are not trusted for load steering
    logic [2:0]  r_op;
    logic [1:0]  r_lane;

    // Architectural load result
    logic [31:0] r_rd;

    // Decode of the op currently presented by the M stage
    logic        w_is_store;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_ack;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Load extraction from the word-aligned read data
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

    // Classify the incoming op and decide whether it may start a bus access
    always_comb begin
        w_is_store   = (memOpIN == OP_SW) || (memOpIN == OP_SH) || (memOpIN == OP_SB);
        w_is_word    = (memOpIN == OP_LW) || (memOpIN == OP_SW);
        w_is_half    = (memOpIN == OP_LH) || (memOpIN == OP_LHU) || (memOpIN == OP_SH);
        w_misaligned = (w_is_word && (addrIN[1:0] != 2'b00)) ||
                       (w_is_half && addrIN[0]);
        w_issue      = (r_state == S_IDLE) && memEnIN && !w_misaligned;
        w_ack        = (r_state == S_REQ) && busAckIN;
        w_timeout    = (r_state == S_REQ) && !busAckIN && (r_wait_cnt == WAIT_LAST);
    end

    // Byte enables and lane-replicated write data for the op being issued
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = storeDataIN;
        case (memOpIN)
            OP_SH: begin
                w_be    = addrIN[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{storeDataIN[15:0]}};
            end
            OP_SB: begin
                w_be    = 4'b0001 << addrIN[1:0];
                w_wdata = {4{storeDataIN[7:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = storeDataIN;
            end
        endcase
    end

    // Steer and extend the returned word using the lane captured at issue
    always_comb begin
        w_ld_byte = busRdataIN[7:0];
        case (r_lane)
            2'd1:    w_ld_byte = busRdataIN[15:8];
            2'd2:    w_ld_byte = busRdataIN[23:16];
            2'd3:    w_ld_byte = busRdataIN[31:24];
            default: w_ld_byte = busRdataIN[7:0];
        endcase
        w_ld_half = r_lane[1] ? busRdataIN[31:16] : busRdataIN[15:0];
        case (r_op)
            OP_LH:   w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            OP_LHU:  w_ld_ext = {16'h0000, w_ld_half};
            OP_LB:   w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            OP_LBU:  w_ld_ext = {24'h000000, w_ld_byte};
            default: w_ld_ext = busRdataIN;
        endcase
    end

    // FSM state register; reset wins over any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: DONE never looks at the held op, so nothing is re-issued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_issue ? S_REQ : S_IDLE;
            S_REQ:   w_state_nxt = (w_ack || w_timeout) ? S_DONE : S_REQ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: stall and alignment exceptions are combinational so the pipeline reacts this cycle
    always_comb begin
        stallOUT   = w_issue || (r_state == S_REQ);
        excAdELOUT = (r_state == S_IDLE) && memEnIN && !w_is_store && w_misaligned;
        excAdESOUT = (r_state == S_IDLE) && memEnIN &&  w_is_store && w_misaligned;
    end

    // Bus request, bus fields, wait counter and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_be    <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_bus_err   <= 1'b0;
            r_wait_cnt  <= 4'h0;
            r_op        <= OP_LW;
            r_lane      <= 2'b00;
            r_rd        <= 32'h0;
        end else begin
            // Error is a single-cycle pulse raised on the cycle the FSM enters DONE
            r_bus_err <= w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {addrIN[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_op        <= memOpIN;
                        r_lane      <= addrIN[1:0];
                        r_wait_cnt  <= 4'h0;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        // An ack on the last wait cycle still completes normally
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_rd <= w_ld_ext;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: begin
                    // DONE: bus fields stay as last driven, request already low
                end
            endcase
        end
    end

    assign busReqOUT    = r_bus_req;
    assign busWeOUT     = r_bus_we;
    assign busAddrOUT   = r_bus_addr;
    assign busByteEnOUT = r_bus_be;
    assign busWdataOUT  = r_bus_wdata;
    assign busErrOUT    = r_bus_err;
    assign RDOUT        = r_rd;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed bench for mem_access_unit with a bus-transaction scoreboard.
// Latency: drives one op at a time, acking after a chosen number of REQ cycles (or never).
// Backpressure: holds the op stable while stallOUT is high and through DONE, as the pipeline would.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memEnIN;
    logic [2:0]  memOpIN;
    logic [31:0] addrIN;
    logic [31:0] storeDataIN;
    logic        busAckIN;
    logic [31:0] busRdataIN;
    logic        busReqOUT;
    logic        busWeOUT;
    logic [31:0] busAddrOUT;
    logic [3:0]  busByteEnOUT;
    logic [31:0] busWdataOUT;
    logic [31:0] RDOUT;
    logic        stallOUT;
    logic        excAdELOUT;
    logic        excAdESOUT;
    logic        busErrOUT;

    int checks = 0;
    int errors = 0;
    int issues = 0;
    logic prev_req = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    bus_exp_t sb[$];

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .memEnIN      (memEnIN),
        .memOpIN      (memOpIN),
        .addrIN       (addrIN),
        .storeDataIN  (storeDataIN),
        .busAckIN     (busAckIN),
        .busRdataIN   (busRdataIN),
        .busReqOUT    (busReqOUT),
        .busWeOUT     (busWeOUT),
        .busAddrOUT   (busAddrOUT),
        .busByteEnOUT (busByteEnOUT),
        .busWdataOUT  (busWdataOUT),
        .RDOUT        (RDOUT),
        .stallOUT     (stallOUT),
        .excAdELOUT   (excAdELOUT),
        .excAdESOUT   (excAdESOUT),
        .busErrOUT    (busErrOUT)
    );

    always #5 clk = ~clk;

    // Count rising edges of the bus request to catch duplicated issues
    always @(posedge clk) begin
        prev_req <= busReqOUT;
        if (busReqOUT === 1'b1 && prev_req !== 1'b1) issues <= issues + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
        case (op)
            3'b110:  model_be = a[1] ? 4'b1100 : 4'b0011;
            3'b111:  model_be = 4'b0001 << a[1:0];
            default: model_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b110:  model_wd = {2{d[15:0]}};
            3'b111:  model_wd = {4{d[7:0]}};
            default: model_wd = d;
        endcase
    endfunction

    // One aligned access: ack_after = REQ cycles before ack (-1 = never ack)
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input int ack_after, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
        bus_exp_t e;
        bus_exp_t got;
        int stalls;
        int k;
        e.we        = op[2] && (op[1:0] != 2'b00);
        e.addr      = {addr[31:2], 2'b00};
        e.be        = model_be(op, addr);
        e.wdata     = model_wd(op, sd);
        e.chk_wdata = e.we;
        sb.push_back(e);

        memEnIN = 1'b1; memOpIN = op; addrIN = addr; storeDataIN = sd; busAckIN = 1'b0;
        #1;
        stalls = 0;
        if (stallOUT === 1'b1) stalls++;
        check({name, "_exc_none"}, {31'b0, excAdELOUT | excAdESOUT}, 32'h0);
        @(posedge clk); #1;
        check({name, "_req_issued"}, {31'b0, busReqOUT}, 32'h1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({name, "_we"},   {31'b0, busWeOUT}, {31'b0, got.we});
            check({name, "_addr"}, busAddrOUT, got.addr);
            check({name, "_be"},   {28'b0, busByteEnOUT}, {28'b0, got.be});
            if (got.chk_wdata) check({name, "_wdata"}, busWdataOUT, got.wdata);
        end
        k = 0;
        while (busReqOUT === 1'b1 && k < 40) begin
            if (k == ack_after) begin busAckIN = 1'b1; busRdataIN = rdata; end
            #1;
            if (stallOUT === 1'b1) stalls++;
            @(posedge clk); #1;
            busAckIN = 1'b0;
            k++;
        end
        // DONE cycle: op still held, pipeline released here
        check({name, "_done_req"}, {31'b0, busReqOUT}, 32'h0);
        check({name, "_err"},      {31'b0, busErrOUT}, {31'b0, exp_err});
        check({name, "_rd"},       RDOUT, exp_rd);
        #1;
        if (stallOUT === 1'b1) stalls++;
        check({name, "_stall_cycles"}, stalls, exp_stall);
        @(posedge clk); #1;
        memEnIN = 1'b0;
        check({name, "_no_reissue"}, {31'b0, busReqOUT}, 32'h0);
        check({name, "_err_pulse_end"}, {31'b0, busErrOUT}, 32'h0);
    endtask

    initial begin
        int iss0;
        reset = 1'b1; memEnIN = 1'b0; memOpIN = 3'b000; addrIN = 32'h0;
        storeDataIN = 32'h0; busAckIN = 1'b0; busRdataIN = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'b0, busReqOUT}, 32'h0);
        check("rst_we",    {31'b0, busWeOUT}, 32'h0);
        check("rst_addr",  busAddrOUT, 32'h0);
        check("rst_be",    {28'b0, busByteEnOUT}, 32'h0);
        check("rst_wdata", busWdataOUT, 32'h0);
        check("rst_rd",    RDOUT, 32'h0);
        check("rst_err",   {31'b0, busErrOUT}, 32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_stall", {31'b0, stallOUT}, 32'h0);
        @(posedge clk); #1;

        // Loads, stores, sign/zero extension
        run_op("lb_13",   3'b011, 32'h00000013, 32'h0, 1, 32'h80AB12CD, 32'hFFFFFF80, 1'b0, 3);
        run_op("sh_22",   3'b110, 32'h00000022, 32'h0000BEEF, 0, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run_op("sb_21",   3'b111, 32'h00000021, 32'h12345677, 0, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run_op("sw_08",   3'b101, 32'h00000008, 32'hCAFEF00D, 2, 32'h0, 32'hFFFFFF80, 1'b0, 4);
        run_op("sh_00",   3'b110, 32'h00000100, 32'h00001234, 0, 32'h0, 32'hFFFFFF80, 1'b0, 2);

        // Misaligned load and store: exception only, no bus, no stall
        memEnIN = 1'b1; memOpIN = 3'b000; addrIN = 32'h00000006;
        #1;
        check("lw6_adel",  {31'b0, excAdELOUT}, 32'h1);
        check("lw6_ades",  {31'b0, excAdESOUT}, 32'h0);
        check("lw6_stall", {31'b0, stallOUT}, 32'h0);
        @(posedge clk); #1;
        check("lw6_noreq", {31'b0, busReqOUT}, 32'h0);
        memOpIN = 3'b110; addrIN = 32'h00000001; storeDataIN = 32'h0000FFFF;
        #1;
        check("sh1_ades",  {31'b0, excAdESOUT}, 32'h1);
        check("sh1_adel",  {31'b0, excAdELOUT}, 32'h0);
        check("sh1_stall", {31'b0, stallOUT}, 32'h0);
        @(posedge clk); #1;
        check("sh1_noreq", {31'b0, busReqOUT}, 32'h0);
        memEnIN = 1'b0;

        // Timeout and last-cycle ack
        run_op("lhu_to",  3'b010, 32'h00000002, 32'h0, -1, 32'h0, 32'hFFFFFF80, 1'b1, 17);
        run_op("lhu_ack", 3'b010, 32'h00000002, 32'h0, 15, 32'h9ABC0000, 32'h00009ABC, 1'b0, 17);
        run_op("lh_2",    3'b001, 32'h00000002, 32'h0, 0, 32'h9ABC0000, 32'hFFFF9ABC, 1'b0, 2);
        run_op("lb_1",    3'b011, 32'h00000041, 32'h0, 0, 32'h00007F00, 32'h0000007F, 1'b0, 2);

        // Back-to-back loads, each issued once
        iss0 = issues;
        run_op("lw_0",    3'b000, 32'h00000000, 32'h0, 0, 32'h11111111, 32'h11111111, 1'b0, 2);
        run_op("lbu_5",   3'b100, 32'h00000005, 32'h0, 0, 32'h0000AA00, 32'h000000AA, 1'b0, 2);
        check("b2b_issues", issues - iss0, 32'd2);

        // Stray ack while idle is ignored
        busAckIN = 1'b1; busRdataIN = 32'h55555555;
        @(posedge clk); #1;
        busAckIN = 1'b0;
        check("stray_rd",  RDOUT, 32'h000000AA);
        check("stray_req", {31'b0, busReqOUT}, 32'h0);
        check("stray_err", {31'b0, busErrOUT}, 32'h0);

        // Reset in the 2nd REQ cycle, then a late ack
        memEnIN = 1'b1; memOpIN = 3'b000; addrIN = 32'h00000040;
        @(posedge clk); #1;
        check("mid_rst_req1", {31'b0, busReqOUT}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; memEnIN = 1'b0; busAckIN = 1'b1; busRdataIN = 32'hDEADBEEF;
        #1;
        check("mid_rst_req",   {31'b0, busReqOUT}, 32'h0);
        check("mid_rst_rd",    RDOUT, 32'h0);
        check("mid_rst_stall", {31'b0, stallOUT}, 32'h0);
        @(posedge clk); #1;
        busAckIN = 1'b0;
        check("late_ack_rd",  RDOUT, 32'h0);
        check("late_ack_req", {31'b0, busReqOUT}, 32'h0);
        check("late_ack_err", {31'b0, busErrOUT}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
